// File: rtl/fdc_sd_arbiter.sv
// fdc_sd_arbiter: merges the four per-drive SD block request channels of the
// floppy controller into the single SD block port of the HPS I/O bridge.
// One host request is outstanding at a time, and the grant is held for the
// whole block transfer. Ack and buffer-write strobes are routed back to the
// granted drive only.
module fdc_sd_arbiter #(
  parameter int TMO_W = 24,    // ack-wait timeout counter width
  parameter bit RR_EN = 1'b1   // 1: round-robin, 0: fixed priority (drive 0 first)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       drv_rd,
  input  logic [3:0]       drv_wr,
  input  logic [3:0][31:0] drv_lba,
  output logic [3:0]       drv_ack,
  input  logic [3:0][7:0]  drv_buff_din,
  output logic [3:0]       drv_buff_wr,
  output logic [31:0]      host_lba,
  output logic             host_rd,
  output logic             host_wr,
  input  logic             host_ack,
  input  logic             host_buff_wr,
  output logic [7:0]       host_buff_din,
  output logic             busy,
  output logic [1:0]       grant_idx,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        grant_reg, grant_next;
  logic [31:0]       lba_reg, lba_next;
  logic              rd_reg, rd_next;
  logic              wr_reg, wr_next;
  logic [3:0]        ack_reg, ack_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [TMO_W-1:0]  tmo_inc;
  logic [1:0]        rr_reg, rr_next;
  logic              timeout_reg, timeout_next;

  // Arbitration result, only acted on while IDLE.
  logic [3:0]        pending;
  logic              found;
  logic [1:0]        win;
  logic [1:0]        search_start;
  logic [1:0]        idx;

  // First pending drive, searching upward (mod 4) from the round-robin pointer.
  always_comb begin
    pending      = drv_rd | drv_wr;
    search_start = RR_EN ? rr_reg : 2'd0;
    found        = 1'b0;
    win          = 2'd0;
    idx          = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = search_start + 2'(k);
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and registered-output logic of the request/transfer FSM.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    lba_next     = lba_reg;
    rd_next      = rd_reg;
    wr_next      = wr_reg;
    ack_next     = ack_reg;
    tmo_next     = tmo_reg;
    rr_next      = rr_reg;
    timeout_next = 1'b0;
    tmo_inc      = tmo_reg + {{(TMO_W-1){1'b0}}, 1'b1};

    case (state_reg)
      IDLE: begin
        ack_next = 4'b0000;
        if (found) begin
          // LBA and operation are frozen here; later drive-side changes are ignored.
          grant_next = win;
          lba_next   = drv_lba[win];
          rd_next    = drv_rd[win];
          wr_next    = !drv_rd[win];
          tmo_next   = '0;
          state_next = REQ;
        end
      end

      REQ: begin
        if (host_ack) begin
          // Request drops on the same edge the ack is seen; ack forwarding starts.
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          ack_next   = 4'b0001 << grant_reg;
          state_next = XFER;
        end else if (&tmo_inc) begin
          // Host never answered: abandon the request and move the pointer on.
          rd_next      = 1'b0;
          wr_next      = 1'b0;
          timeout_next = 1'b1;
          tmo_next     = tmo_inc;
          rr_next      = grant_reg + 2'd1;
          state_next   = IDLE;
        end else begin
          tmo_next = tmo_inc;
        end
      end

      XFER: begin
        if (host_ack) begin
          ack_next = 4'b0001 << grant_reg;
        end else begin
          ack_next   = 4'b0000;
          rr_next    = grant_reg + 2'd1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= IDLE;
      grant_reg   <= 2'd0;
      lba_reg     <= 32'd0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      ack_reg     <= 4'b0000;
      tmo_reg     <= '0;
      rr_reg      <= 2'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      lba_reg     <= lba_next;
      rd_reg      <= rd_next;
      wr_reg      <= wr_next;
      ack_reg     <= ack_next;
      tmo_reg     <= tmo_next;
      rr_reg      <= rr_next;
      timeout_reg <= timeout_next;
    end
  end

  // Buffer write strobe reaches only the granted drive, and only during XFER.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buff_wr
      assign drv_buff_wr[gi] = (state_reg == XFER) && host_buff_wr &&
                               (grant_reg == 2'(gi));
    end
  endgenerate

  assign host_buff_din = drv_buff_din[grant_reg];
  assign host_lba      = lba_reg;
  assign host_rd       = rd_reg;
  assign host_wr       = wr_reg;
  assign drv_ack       = ack_reg;
  assign busy          = (state_reg != IDLE);
  assign grant_idx     = grant_reg;
  assign timeout       = timeout_reg;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed bench for fdc_sd_arbiter. A round-robin instance and a
// fixed-priority instance share all inputs; their FSM timing is identical,
// so only their grant choices differ.
module tb_fdc_sd_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       drv_rd, drv_wr;
  logic [3:0][31:0] drv_lba;
  logic [3:0][7:0]  drv_buff_din;
  logic             host_ack, host_buff_wr;

  logic [3:0]  drv_ack, drv_buff_wr;
  logic [31:0] host_lba;
  logic        host_rd, host_wr, busy, timeout;
  logic [7:0]  host_buff_din;
  logic [1:0]  grant_idx;

  logic [3:0]  f_drv_ack, f_drv_buff_wr;
  logic [31:0] f_host_lba;
  logic        f_host_rd, f_host_wr, f_busy, f_timeout;
  logic [7:0]  f_host_buff_din;
  logic [1:0]  f_grant_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fdc_sd_arbiter #(.TMO_W(4), .RR_EN(1'b1)) dut (
    .CLK(clk), .RESET(rst),
    .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba), .drv_ack(drv_ack),
    .drv_buff_din(drv_buff_din), .drv_buff_wr(drv_buff_wr),
    .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr),
    .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din),
    .busy(busy), .grant_idx(grant_idx), .timeout(timeout)
  );

  fdc_sd_arbiter #(.TMO_W(4), .RR_EN(1'b0)) dut_fixed (
    .CLK(clk), .RESET(rst),
    .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba), .drv_ack(f_drv_ack),
    .drv_buff_din(drv_buff_din), .drv_buff_wr(f_drv_buff_wr),
    .host_lba(f_host_lba), .host_rd(f_host_rd), .host_wr(f_host_wr),
    .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(f_host_buff_din),
    .busy(f_busy), .grant_idx(f_grant_idx), .timeout(f_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    drv_rd       = 4'b0000;
    drv_wr       = 4'b0000;
    host_ack     = 1'b0;
    host_buff_wr = 1'b0;
    tick();
    tick();
    chk("rst_host_rd", 32'(host_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_lba", host_lba, 32'd0);
    chk("rst_drv_ack", 32'(drv_ack), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !(host_rd || host_wr); i++) tick();
    chk("wait_req", 32'(host_rd | host_wr), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic ack_xfer(input int n);
    host_ack = 1'b1;
    repeat (n) tick();
    host_ack = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    drv_lba      = '0;
    drv_buff_din = '0;

    // Single read on drive 0
    do_reset();
    chk("rst_timeout", 32'(timeout), 32'd0);
    drv_rd = 4'b0001;
    drv_lba[0] = 32'h12;
    tick();
    chk("rd_host_rd", 32'(host_rd), 32'd1);
    chk("rd_host_wr", 32'(host_wr), 32'd0);
    chk("rd_lba", host_lba, 32'h12);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_grant", 32'(grant_idx), 32'd0);
    drv_rd = 4'b0000;
    tick();
    chk("rd_hold", 32'(host_rd), 32'd1);
    host_ack = 1'b1;
    tick();
    chk("rd_drop_on_ack", 32'(host_rd), 32'd0);
    chk("rd_ack_dly", 32'(drv_ack), 32'b0001);
    tick();
    tick();
    chk("rd_ack_held", 32'(drv_ack), 32'b0001);
    host_ack = 1'b0;
    tick();
    chk("rd_ack_fall", 32'(drv_ack), 32'd0);
    chk("rd_busy_fall", 32'(busy), 32'd0);

    // Round-robin vs fixed priority with all four drives requesting
    do_reset();
    for (int i = 0; i < 4; i++) drv_lba[i] = 32'h100 + 32'(i);
    drv_rd = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_req();
      chk($sformatf("rr_grant%0d", i), 32'(grant_idx), 32'(i % 4));
      chk($sformatf("rr_lba%0d", i), host_lba, 32'h100 + 32'(i % 4));
      chk($sformatf("fix_grant%0d", i), 32'(f_grant_idx), 32'd0);
      ack_xfer(2);
    end
    drv_rd = 4'b0000;
    tick();

    // Write on drive 2 with buffer routing
    do_reset();
    drv_lba[2] = 32'h2222;
    drv_buff_din = {8'h00, 8'hA5, 8'h00, 8'h00};
    drv_wr = 4'b0100;
    wait_req();
    chk("wr_host_wr", 32'(host_wr), 32'd1);
    chk("wr_host_rd", 32'(host_rd), 32'd0);
    chk("wr_grant", 32'(grant_idx), 32'd2);
    chk("wr_din", 32'(host_buff_din), 32'hA5);
    chk("wr_lba", host_lba, 32'h2222);
    drv_wr = 4'b0000;
    host_buff_wr = 1'b1;
    #1;
    chk("wr_bwr_req", 32'(drv_buff_wr), 32'd0);
    host_buff_wr = 1'b0;
    host_ack = 1'b1;
    tick();
    host_buff_wr = 1'b1;
    #1;
    chk("wr_bwr_xfer", 32'(drv_buff_wr), 32'b0100);
    host_buff_wr = 1'b0;
    #1;
    chk("wr_bwr_low", 32'(drv_buff_wr), 32'd0);
    ack_xfer(1);

    // rd+wr on the same drive, withdrawal and LBA change during REQ
    do_reset();
    drv_lba[1] = 32'hAAAA;
    drv_rd = 4'b0010;
    drv_wr = 4'b0010;
    wait_req();
    chk("rw_host_rd", 32'(host_rd), 32'd1);
    chk("rw_host_wr", 32'(host_wr), 32'd0);
    chk("rw_grant", 32'(grant_idx), 32'd1);
    drv_rd = 4'b0000;
    drv_wr = 4'b0000;
    drv_lba[1] = 32'hBBBB;
    tick();
    chk("rw_lba_frozen", host_lba, 32'hAAAA);
    chk("rw_still_req", 32'(host_rd), 32'd1);
    host_ack = 1'b1;
    tick();
    chk("rw_ack_routed", 32'(drv_ack), 32'b0010);
    host_ack = 1'b0;
    wait_idle();

    // Timeout on drive 3 (after a drive-2 transfer so the pointer sits at 3)
    do_reset();
    drv_rd = 4'b0100;
    wait_req();
    drv_rd = 4'b0000;
    ack_xfer(1);
    drv_rd = 4'b1000;
    wait_req();
    chk("tmo_grant", 32'(grant_idx), 32'd3);
    drv_rd = 4'b0000;
    n = 0;
    while (host_rd && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", 32'(n), 32'd15);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_pulse_fix", 32'(f_timeout), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    drv_rd = 4'b1001;
    tick();
    chk("tmo_one_cycle", 32'(timeout), 32'd0);
    chk("tmo_next_grant", 32'(grant_idx), 32'd0);
    chk("tmo_next_req", 32'(host_rd), 32'd1);
    drv_rd = 4'b0000;
    ack_xfer(1);

    // Reset in the middle of a transfer on drive 2
    do_reset();
    drv_wr = 4'b0100;
    wait_req();
    drv_wr = 4'b0000;
    host_ack = 1'b1;
    tick();
    chk("mrst_pre_ack", 32'(drv_ack), 32'b0100);
    host_buff_wr = 1'b1;
    #1;
    chk("mrst_pre_bwr", 32'(drv_buff_wr), 32'b0100);
    rst = 1'b1;
    #1;
    chk("mrst_ack", 32'(drv_ack), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant_idx), 32'd0);
    chk("mrst_wr", 32'(host_wr), 32'd0);
    chk("mrst_bwr", 32'(drv_buff_wr), 32'd0);
    host_ack = 1'b0;
    host_buff_wr = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
